// File: rtl/conv2d_layer_scheduler_if.sv
// Control/status bundle between the layer scheduler and the PE, line buffer and kernel loader.
// The scheduler connects through "master"; the surrounding datapath through "slave".
interface conv2d_layer_scheduler_if #(
  parameter int unsigned CH_WIDTH  = 10,
  parameter int unsigned ROW_WIDTH = 8,
  parameter int unsigned COL_WIDTH = 8
);
  logic                 start;
  logic [CH_WIDTH-1:0]  cfg_num_ch_m1;
  logic [ROW_WIDTH-1:0] cfg_num_rows_m1;
  logic [COL_WIDTH-1:0] cfg_row_len_m1;
  logic                 kernel_valid;
  logic                 pix_valid;
  logic                 PE_ready;
  logic                 PE_with_buffers_IDLE;

  logic                 Load_kernel_reg;
  logic                 Stream_mid_row;
  logic                 Stream_last_row;
  logic                 Output_valid;
  logic                 Done_1row;
  logic                 last_channel;
  logic [COL_WIDTH-1:0] b_counter_output;
  logic [CH_WIDTH-1:0]  channel_idx;
  logic [ROW_WIDTH-1:0] row_idx;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, cfg_num_ch_m1, cfg_num_rows_m1, cfg_row_len_m1,
           kernel_valid, pix_valid, PE_ready, PE_with_buffers_IDLE,
    output Load_kernel_reg, Stream_mid_row, Stream_last_row, Output_valid,
           Done_1row, last_channel, b_counter_output, channel_idx, row_idx,
           busy, done
  );

  modport slave (
    output start, cfg_num_ch_m1, cfg_num_rows_m1, cfg_row_len_m1,
           kernel_valid, pix_valid, PE_ready, PE_with_buffers_IDLE,
    input  Load_kernel_reg, Stream_mid_row, Stream_last_row, Output_valid,
           Done_1row, last_channel, b_counter_output, channel_idx, row_idx,
           busy, done
  );
endinterface

// File: rtl/conv2d_layer_scheduler.sv
// Layer-pass sequencer for the 3x3 convolution PE: walks channels and rows, requests
// kernel loads, frames each row for the PE control unit and waits for the PE to drain.
module conv2d_layer_scheduler #(
  parameter int unsigned CH_WIDTH  = 10,
  parameter int unsigned ROW_WIDTH = 8,
  parameter int unsigned COL_WIDTH = 8
) (
  input logic                   clk,
  input logic                   Reset,
  conv2d_layer_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KERNEL,
    S_WAIT_PE,
    S_STREAM,
    S_ROW_DONE,
    S_CH_DONE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CH_WIDTH-1:0]  ch_q, ch_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [CH_WIDTH-1:0]  ch_m1_q, ch_m1_d;
  logic [ROW_WIDTH-1:0] rows_m1_q, rows_m1_d;
  logic [COL_WIDTH-1:0] len_m1_q, len_m1_d;

  logic busy_q;
  logic stream_mid_q;
  logic stream_last_q;
  logic done_1row_q;
  logic done_q;
  logic last_ch_q;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    row_d     = row_q;
    col_d     = col_q;
    ch_m1_d   = ch_m1_q;
    rows_m1_d = rows_m1_q;
    len_m1_d  = len_m1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ch_d      = '0;
          row_d     = '0;
          col_d     = '0;
          ch_m1_d   = bus.cfg_num_ch_m1;
          rows_m1_d = bus.cfg_num_rows_m1;
          len_m1_d  = bus.cfg_row_len_m1;
          state_d   = S_LOAD_KERNEL;
        end
      end
      S_LOAD_KERNEL: begin
        if (bus.kernel_valid) begin
          state_d = S_WAIT_PE;
        end
      end
      S_WAIT_PE: begin
        if (bus.PE_ready) begin
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.pix_valid) begin
          // Column parks on the final index so the last window keeps its address.
          if (col_q == len_m1_q) begin
            state_d = S_ROW_DONE;
          end else begin
            col_d = col_q + COL_WIDTH'(1);
          end
        end
      end
      S_ROW_DONE: begin
        if (row_q == rows_m1_q) begin
          row_d   = '0;
          state_d = S_CH_DONE;
        end else begin
          row_d   = row_q + ROW_WIDTH'(1);
          state_d = S_WAIT_PE;
        end
      end
      S_CH_DONE: begin
        if (ch_q == ch_m1_q) begin
          state_d = S_DRAIN;
        end else begin
          ch_d    = ch_q + CH_WIDTH'(1);
          state_d = S_LOAD_KERNEL;
        end
      end
      S_DRAIN: begin
        if (bus.PE_with_buffers_IDLE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      row_q         <= '0;
      col_q         <= '0;
      ch_m1_q       <= '0;
      rows_m1_q     <= '0;
      len_m1_q      <= '0;
      busy_q        <= 1'b0;
      stream_mid_q  <= 1'b0;
      stream_last_q <= 1'b0;
      done_1row_q   <= 1'b0;
      done_q        <= 1'b0;
      last_ch_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      row_q         <= row_d;
      col_q         <= col_d;
      ch_m1_q       <= ch_m1_d;
      rows_m1_q     <= rows_m1_d;
      len_m1_q      <= len_m1_d;
      busy_q        <= (state_d != S_IDLE);
      stream_mid_q  <= (state_d == S_STREAM) && (row_d != rows_m1_d);
      stream_last_q <= (state_d == S_STREAM) && (row_d == rows_m1_d);
      done_1row_q   <= (state_d == S_ROW_DONE);
      done_q        <= (state_d == S_DONE);
      last_ch_q     <= (state_d != S_IDLE) && (ch_d == ch_m1_d);
    end
  end

  // The load strobe must coincide with the cycle the kernel sits on kernel_flat.
  assign bus.Load_kernel_reg  = (state_q == S_LOAD_KERNEL) && bus.kernel_valid;
  assign bus.Output_valid     = (state_q == S_STREAM) && bus.pix_valid;
  assign bus.Stream_mid_row   = stream_mid_q;
  assign bus.Stream_last_row  = stream_last_q;
  assign bus.Done_1row        = done_1row_q;
  assign bus.done             = done_q;
  assign bus.busy             = busy_q;
  assign bus.last_channel     = last_ch_q;
  assign bus.b_counter_output = col_q;
  assign bus.channel_idx      = ch_q;
  assign bus.row_idx          = row_q;

endmodule

// File: tb/tb_conv2d_layer_scheduler.sv
// Directed self-checking bench for conv2d_layer_scheduler: reset behaviour, exact timing of a
// single-pixel pass, and counted/modelled multi-channel passes with stalls and drain waits.
module tb_conv2d_layer_scheduler;
  localparam int unsigned CH_W  = 10;
  localparam int unsigned ROW_W = 8;
  localparam int unsigned COL_W = 8;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  conv2d_layer_scheduler_if #(.CH_WIDTH(CH_W), .ROW_WIDTH(ROW_W), .COL_WIDTH(COL_W)) bus ();

  conv2d_layer_scheduler #(.CH_WIDTH(CH_W), .ROW_WIDTH(ROW_W), .COL_WIDTH(COL_W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] flags();
    return {bus.Load_kernel_reg, bus.Stream_mid_row, bus.Stream_last_row, bus.Output_valid,
            bus.Done_1row, bus.last_channel, bus.busy, bus.done};
  endfunction

  task automatic set_cfg(input int ch_m1, input int rows_m1, input int len_m1);
    bus.cfg_num_ch_m1   = CH_W'(ch_m1);
    bus.cfg_num_rows_m1 = ROW_W'(rows_m1);
    bus.cfg_row_len_m1  = COL_W'(len_m1);
  endtask

  // Runs one full pass, tracking expected channel/row/column in a small model.
  task automatic run_pass(input int ch_m1, input int rows_m1, input int len_m1,
                          input bit toggle_pix, input int pe_stall, input int kv_delay,
                          input int drain_hold, input bit start_poke);
    int loads = 0, rows_done = 0, valids = 0, end_hits = 0, rv = 0;
    int col_e = 0, row_e = 0, ch_e = 0, kv_cnt = 0;
    int stall_from = -1, stall_to = -1, last_d = -1, poke_cyc = -1;
    bit done_seen = 1'b0, first_d = 1'b1;
    set_cfg(ch_m1, rows_m1, len_m1);
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      @(negedge clk);
      bus.start                = (cyc == 0) || (cyc == poke_cyc);
      bus.kernel_valid         = (kv_cnt >= kv_delay);
      bus.PE_ready             = !(cyc >= stall_from && cyc <= stall_to);
      bus.pix_valid            = toggle_pix ? (cyc % 2 == 0) : 1'b1;
      bus.PE_with_buffers_IDLE = (drain_hold == 0) || (last_d >= 0 && cyc >= last_d + drain_hold);
      kv_cnt++;
      #1;
      if (bus.Load_kernel_reg) begin
        loads++;
        chk("load_needs_kv", 32'(bus.kernel_valid), 32'd1);
      end
      if (!bus.PE_ready)
        chk("no_stream_in_stall",
            32'({bus.Stream_mid_row, bus.Stream_last_row, bus.Output_valid}), 32'd0);
      if (bus.Stream_mid_row || bus.Stream_last_row) begin
        chk("col",       32'(bus.b_counter_output), 32'(col_e));
        chk("row",       32'(bus.row_idx),          32'(row_e));
        chk("ch",        32'(bus.channel_idx),      32'(ch_e));
        chk("last_row",  32'(bus.Stream_last_row),  32'(row_e == rows_m1));
        chk("mid_row",   32'(bus.Stream_mid_row),   32'(row_e != rows_m1));
        chk("last_ch",   32'(bus.last_channel),     32'(ch_e == ch_m1));
        chk("ov_eq_pix", 32'(bus.Output_valid),     32'(bus.pix_valid));
      end else begin
        chk("ov_outside_stream", 32'(bus.Output_valid), 32'd0);
      end
      if (bus.Output_valid) begin
        valids++;
        rv++;
        if (int'(bus.b_counter_output) == len_m1) end_hits++;
        if (col_e < len_m1) col_e++;
        if (start_poke && poke_cyc < 0 && row_e == 1) poke_cyc = cyc + 1;
      end
      if (bus.Done_1row) begin
        rows_done++;
        chk("row_valids", 32'(rv), 32'(len_m1 + 1));
        rv    = 0;
        col_e = 0;
        if (first_d && pe_stall > 0) begin
          stall_from = cyc + 1;
          stall_to   = cyc + pe_stall;
        end
        first_d = 1'b0;
        if (row_e == rows_m1) begin
          row_e = 0;
          if (ch_e == ch_m1) last_d = cyc;
          else begin
            ch_e++;
            kv_cnt = 0;
          end
        end else begin
          row_e++;
        end
      end
      if (bus.done) begin
        done_seen = 1'b1;
        if (drain_hold > 0) chk("done_after_idle", 32'(cyc), 32'(last_d + drain_hold + 1));
        else                chk("done_latency",    32'(cyc), 32'(last_d + 3));
      end
    end
    chk("done_seen", 32'(done_seen),  32'd1);
    chk("loads",     32'(loads),      32'(ch_m1 + 1));
    chk("rows_done", 32'(rows_done),  32'((ch_m1 + 1) * (rows_m1 + 1)));
    chk("valids",    32'(valids),     32'((ch_m1 + 1) * (rows_m1 + 1) * (len_m1 + 1)));
    chk("end_hits",  32'(end_hits),   32'((ch_m1 + 1) * (rows_m1 + 1)));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("done_one_cycle",  32'(bus.done), 32'd0);
  endtask

  // {Load, Smid, Slast, Ovalid, Done1row, last_ch, busy, done} per cycle of a 1x1x1 pass
  logic [7:0] sp_exp [9] = '{8'h00, 8'h86, 8'h06, 8'h36, 8'h0E, 8'h06, 8'h06, 8'h07, 8'h00};

  initial begin
    bit hit;
    Reset                    = 1'b1;
    bus.start                = 1'b0;
    bus.kernel_valid         = 1'b0;
    bus.pix_valid            = 1'b0;
    bus.PE_ready             = 1'b0;
    bus.PE_with_buffers_IDLE = 1'b0;
    set_cfg(0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_flags", 32'(flags()),                32'd0);
    chk("reset_col",   32'(bus.b_counter_output),   32'd0);
    chk("reset_ch",    32'(bus.channel_idx),        32'd0);
    chk("reset_row",   32'(bus.row_idx),            32'd0);
    Reset = 1'b0;

    // Reset in the middle of channel 1, column 4.
    set_cfg(1, 2, 7);
    bus.kernel_valid         = 1'b1;
    bus.pix_valid            = 1'b1;
    bus.PE_ready             = 1'b1;
    bus.PE_with_buffers_IDLE = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.Output_valid && bus.channel_idx == 1 && bus.b_counter_output == 4) hit = 1'b1;
    end
    chk("rst_reached_col4", 32'(hit), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_flags", 32'(flags()),              32'd0);
    chk("midrst_col",   32'(bus.b_counter_output), 32'd0);
    chk("midrst_ch",    32'(bus.channel_idx),      32'd0);
    chk("midrst_row",   32'(bus.row_idx),          32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_stays_idle", 32'(flags()), 32'd0);
    run_pass(1, 2, 7, 1'b0, 0, 0, 0, 1'b0);

    // Single-pixel layer with every input held high: exact per-cycle profile.
    set_cfg(0, 0, 0);
    bus.kernel_valid         = 1'b1;
    bus.pix_valid            = 1'b1;
    bus.PE_ready             = 1'b1;
    bus.PE_with_buffers_IDLE = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      #1;
      chk($sformatf("sp_cycle%0d", c), 32'(flags()), 32'(sp_exp[c]));
      if (c == 3) chk("sp_col0", 32'(bus.b_counter_output), 32'd0);
    end

    run_pass(2, 3, 15, 1'b0, 0, 0, 0, 1'b0);   // 3 loads, 12 rows, 192 windows
    run_pass(1, 1, 9, 1'b1, 0, 0, 0, 1'b0);    // pix_valid toggling
    run_pass(1, 2, 5, 1'b0, 20, 5, 0, 1'b0);   // PE_ready stall and late kernels
    run_pass(1, 2, 5, 1'b0, 0, 0, 50, 1'b1);   // start poke mid-stream, long drain

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
